// File: rtl/detector_sentido.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | detector_sentido : two-beam passage direction detector (in/out/error)    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module detector_sentido #(
   parameter int DEB_CYCLES = 4,
   parameter int TIMEOUT    = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic sensor_a,
   input  logic sensor_b,
   output logic entrada,
   output logic salida,
   output logic error,
   output logic ocupado
);

   localparam int DW = $clog2(DEB_CYCLES) + 1;
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] E1       = 3'd1;
   localparam logic [2:0] E2       = 3'd2;
   localparam logic [2:0] E3       = 3'd3;
   localparam logic [2:0] S1       = 3'd4;
   localparam logic [2:0] S2       = 3'd5;
   localparam logic [2:0] S3       = 3'd6;
   localparam logic [2:0] WAIT_CLR = 3'd7;

   logic [1:0] raw;
   logic [1:0] deb;

   assign raw = {sensor_a, sensor_b};

   // Bit 1 carries sensor A, bit 0 sensor B, so deb reads as the (A,B) pair.
   genvar i;
   generate
      for (i = 0; i < 2; i++) begin : g_sensor
         logic          meta;
         logic          sync;
         logic          val;
         logic [DW-1:0] cnt;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               meta <= 1'b0;
               sync <= 1'b0;
               val  <= 1'b0;
               cnt  <= '0;
            end else begin
               meta <= raw[i];
               sync <= meta;
               if (sync == val) begin
                  cnt <= '0;
               end else if (cnt == DEB_LAST) begin
                  val <= sync;
                  cnt <= '0;
               end else begin
                  cnt <= cnt + DW'(1);
               end
            end
         end

         assign deb[i] = val;
      end
   endgenerate

   logic [2:0]    state;
   logic [2:0]    state_nxt;
   logic [TW-1:0] tcnt;
   logic          passage;
   logic          timeout;
   logic          entrada_d;
   logic          salida_d;
   logic          error_d;

   assign passage = (state != IDLE) && (state != WAIT_CLR);
   assign timeout = passage && (tcnt == TIMEOUT_MAX);

   // Runs across all passage states and saturates instead of wrapping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tcnt <= '0;
      end else if (!passage) begin
         tcnt <= '0;
      end else if (tcnt != TIMEOUT_MAX) begin
         tcnt <= tcnt + TW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         entrada <= 1'b0;
         salida  <= 1'b0;
         error   <= 1'b0;
      end else begin
         state   <= state_nxt;
         entrada <= entrada_d;
         salida  <= salida_d;
         error   <= error_d;
      end
   end

   always_comb begin
      state_nxt = state;
      if (timeout) begin
         state_nxt = WAIT_CLR;
      end else begin
         case (state)
            IDLE: begin
               case (deb)
                  2'b10:   state_nxt = E1;
                  2'b01:   state_nxt = S1;
                  2'b11:   state_nxt = WAIT_CLR;
                  default: state_nxt = IDLE;
               endcase
            end
            E1: begin
               case (deb)
                  2'b11:   state_nxt = E2;
                  2'b00:   state_nxt = IDLE;
                  2'b01:   state_nxt = WAIT_CLR;
                  default: state_nxt = E1;
               endcase
            end
            E2: begin
               case (deb)
                  2'b01:   state_nxt = E3;
                  2'b10:   state_nxt = E1;
                  2'b00:   state_nxt = WAIT_CLR;
                  default: state_nxt = E2;
               endcase
            end
            E3: begin
               case (deb)
                  2'b00:   state_nxt = IDLE;
                  2'b11:   state_nxt = E2;
                  2'b10:   state_nxt = WAIT_CLR;
                  default: state_nxt = E3;
               endcase
            end
            S1: begin
               case (deb)
                  2'b11:   state_nxt = S2;
                  2'b00:   state_nxt = IDLE;
                  2'b10:   state_nxt = WAIT_CLR;
                  default: state_nxt = S1;
               endcase
            end
            S2: begin
               case (deb)
                  2'b10:   state_nxt = S3;
                  2'b01:   state_nxt = S1;
                  2'b00:   state_nxt = WAIT_CLR;
                  default: state_nxt = S2;
               endcase
            end
            S3: begin
               case (deb)
                  2'b00:   state_nxt = IDLE;
                  2'b11:   state_nxt = S2;
                  2'b01:   state_nxt = WAIT_CLR;
                  default: state_nxt = S3;
               endcase
            end
            WAIT_CLR: begin
               if (deb == 2'b00) begin
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Pulses derive from the transition itself; only E3/S3 reach IDLE on 00
   // as a completed passage, every other IDLE entry is a backout.
   always_comb begin
      entrada_d = (state == E3) && (state_nxt == IDLE);
      salida_d  = (state == S3) && (state_nxt == IDLE);
      error_d   = (state != WAIT_CLR) && (state_nxt == WAIT_CLR);
      ocupado   = (state != IDLE);
   end

endmodule
`default_nettype wire

// File: tb/tb_detector_sentido.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_detector_sentido : scoreboard bench for detector_sentido              |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_detector_sentido;

   localparam int DEB_CYCLES = 4;
   localparam int TIMEOUT    = 1000;

   localparam logic [2:0] EV_ENT = 3'b100;
   localparam logic [2:0] EV_SAL = 3'b010;
   localparam logic [2:0] EV_ERR = 3'b001;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sensor_a = 1'b0;
   logic sensor_b = 1'b0;
   logic entrada;
   logic salida;
   logic error;
   logic ocupado;

   int n_checks = 0;
   int n_fail   = 0;
   int cars     = 0;
   logic [2:0] exp_q[$];
   logic [2:0] prev_obs = 3'b000;
   logic       ocupado_seen;

   detector_sentido #(
      .DEB_CYCLES(DEB_CYCLES),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .sensor_a(sensor_a),
      .sensor_b(sensor_b),
      .entrada (entrada),
      .salida  (salida),
      .error   (error),
      .ocupado (ocupado)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic hold(input logic [1:0] ab, input int n);
      sensor_a = ab[1];
      sensor_b = ab[0];
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic passage(input logic [1:0] l0, input logic [1:0] l1,
                          input logic [1:0] l2, input logic [1:0] l3);
      hold(l0, 10);
      hold(l1, 10);
      hold(l2, 10);
      hold(l3, 10);
      hold(2'b00, 20);
   endtask

   task automatic settle(input string tag);
      @(negedge clk);
      check({tag, "_drain"}, exp_q.size(), 0);
      check({tag, "_ocupado"}, ocupado, 1'b0);
   endtask

   // Pulse monitor: each observed pulse consumes one scoreboard entry.
   initial begin
      logic [2:0] obs;
      forever begin
         @(negedge clk);
         obs = {entrada, salida, error};
         if (rst && obs != 3'b000) begin
            check("pulse_width", prev_obs, 3'b000);
            if (exp_q.size() == 0)
               check("unexpected_pulse", obs, 3'b000);
            else
               check("pulse_kind", obs, exp_q.pop_front());
            if (entrada && cars < 7) cars++;
            if (salida && cars > 0) cars--;
         end
         prev_obs = rst ? obs : 3'b000;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      #2 rst = 1'b0;
      #1;
      check("rst_entrada", entrada, 1'b0);
      check("rst_salida", salida, 1'b0);
      check("rst_error", error, 1'b0);
      check("rst_ocupado", ocupado, 1'b0);
      sensor_a = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("rst_hold_ocupado", ocupado, 1'b0);
      sensor_a = 1'b0;
      repeat (8) @(posedge clk);
      #3 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Inbound
      exp_q.push_back(EV_ENT);
      hold(2'b10, 10);
      hold(2'b11, 10);
      @(negedge clk);
      check("in_mid_ocupado", ocupado, 1'b1);
      hold(2'b01, 10);
      hold(2'b00, 20);
      settle("inbound");

      // Outbound
      exp_q.push_back(EV_SAL);
      passage(2'b00, 2'b01, 2'b11, 2'b10);
      settle("outbound");

      // Backout
      passage(2'b10, 2'b11, 2'b10, 2'b00);
      settle("backout");

      // Short glitch on A while idle
      ocupado_seen = 1'b0;
      sensor_a = 1'b1;
      repeat (2) @(posedge clk);
      #1 sensor_a = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (ocupado) ocupado_seen = 1'b1;
      end
      check("glitch_ocupado", ocupado_seen, 1'b0);
      settle("glitch");

      // Illegal sequence 10 -> 01
      exp_q.push_back(EV_ERR);
      hold(2'b10, 10);
      hold(2'b01, 20);
      @(negedge clk);
      check("illegal_wait_ocupado", ocupado, 1'b1);
      check("illegal_err_seen", exp_q.size(), 0);
      hold(2'b00, 20);
      settle("illegal");

      // Timeout while parked in E1
      exp_q.push_back(EV_ERR);
      hold(2'b10, TIMEOUT + 5);
      hold(2'b00, 20);
      settle("timeout");

      // Chained passages into a downstream car counter
      cars = 0;
      repeat (3) begin
         exp_q.push_back(EV_ENT);
         passage(2'b10, 2'b11, 2'b01, 2'b00);
      end
      @(negedge clk);
      check("chain_in_cars", cars, 3);
      exp_q.push_back(EV_SAL);
      passage(2'b01, 2'b11, 2'b10, 2'b00);
      @(negedge clk);
      check("chain_out_cars", cars, 2);
      settle("chain");

      // Reset mid-passage with both beams still blocked
      hold(2'b10, 10);
      hold(2'b11, 10);
      @(negedge clk);
      check("mid_pre_ocupado", ocupado, 1'b1);
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("mid_async_ocupado", ocupado, 1'b0);
      check("mid_async_pulses", {entrada, salida, error}, 3'b000);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      exp_q.push_back(EV_ERR);
      hold(2'b11, 20);
      @(negedge clk);
      check("mid_wait_ocupado", ocupado, 1'b1);
      hold(2'b00, 20);
      settle("midreset");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
